// File: rtl/multdiv_pkg.sv
// Shared constants, FSM state type and helpers for the iterative multiply/divide unit.
// Pure declarations: no latency, no flow control.
package multdiv_pkg;

  localparam int DATA_W = 32;
  localparam int ITERS  = 32;
  localparam int CNT_W  = $clog2(ITERS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] v);
    return v[DATA_W-1] ? -v : v;
  endfunction

endpackage

// File: rtl/multdiv_div_step.sv
// One restoring-division step on magnitudes: shift in the next dividend bit, trial subtract, emit a quotient bit.
// Combinational, zero latency, no flow control.
module multdiv_div_step
  import multdiv_pkg::*;
(
  input  logic [DATA_W-1:0] rem_in,
  input  logic [DATA_W-1:0] quo_in,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] rem_out,
  output logic [DATA_W-1:0] quo_out
);

  logic [DATA_W:0] shifted;
  logic [DATA_W:0] diff;
  logic            qbit;

  // The partial remainder is always below the divisor, so the shifted value fits in DATA_W+1 bits
  // and the borrow out of the subtraction is the inverse of the quotient bit.
  always_comb begin
    shifted = {rem_in, quo_in[DATA_W-1]};
    diff    = shifted - {1'b0, divisor};
    qbit    = ~diff[DATA_W];
    rem_out = qbit ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];
    quo_out = {quo_in[DATA_W-2:0], qbit};
  end

endmodule

// File: rtl/multdiv.sv
// Iterative signed 32x32 multiply / 32/32 divide; result and ready pulse arrive 33 edges after the start edge.
// No backpressure: a new start aborts any operation in flight; the ready pulse is never held.
module multdiv #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] data_operandA,
  input  logic [DATA_W-1:0] data_operandB,
  input  logic              ctrl_MULT,
  input  logic              ctrl_DIV,
  input  logic              clock,
  output logic [DATA_W-1:0] data_result,
  output logic              data_exception,
  output logic              data_resultRDY,
  input  logic              reset
);

  import multdiv_pkg::*;

  localparam logic [DATA_W-1:0] INT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt;
  logic [2*DATA_W-1:0] acc;        // multiply: {partial product, multiplier}; divide: {remainder, quotient}
  logic [DATA_W-1:0]   opnd_b;     // magnitude of multiplicand or divisor
  logic                op_div;
  logic                neg;
  logic                special;
  logic                start, load, step, finish;

  logic [DATA_W:0]     add_sum;
  logic [2*DATA_W-1:0] mult_nxt;
  logic [DATA_W-1:0]   rem_nxt, quo_nxt;
  logic [2*DATA_W-1:0] prod_signed;
  logic [DATA_W-1:0]   quo_signed;
  logic [DATA_W-1:0]   fin_res;
  logic                fin_exc;

  assign start = ctrl_MULT | ctrl_DIV;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = ctrl_MULT ? MULT : DIV;
    end else begin
      case (state)
        IDLE:     state_nxt = IDLE;
        MULT,
        DIV:      state_nxt = (cnt == CNT_W'(ITERS-1)) ? DONE : state;
        DONE:     state_nxt = IDLE;
        default:  state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    load   = start;
    step   = ((state == MULT) || (state == DIV)) && !start;
    finish = (state == DONE);
  end

  // Shift-add multiply on magnitudes: conditionally add into the upper half, then shift right.
  always_comb begin
    add_sum  = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, opnd_b} : {(DATA_W+1){1'b0}});
    mult_nxt = {add_sum, acc[DATA_W-1:1]};
  end

  multdiv_div_step u_div_step (
    .rem_in  (acc[2*DATA_W-1:DATA_W]),
    .quo_in  (acc[DATA_W-1:0]),
    .divisor (opnd_b),
    .rem_out (rem_nxt),
    .quo_out (quo_nxt)
  );

  always_comb begin
    prod_signed = neg ? -acc : acc;
    quo_signed  = neg ? -acc[DATA_W-1:0] : acc[DATA_W-1:0];
    if (op_div) begin
      fin_res = special ? {DATA_W{1'b0}} : quo_signed;
      fin_exc = special;
    end else begin
      fin_res = prod_signed[DATA_W-1:0];
      // Product fits in DATA_W bits only if the upper half is a pure sign extension.
      fin_exc = !((&prod_signed[2*DATA_W-1:DATA_W-1]) || !(|prod_signed[2*DATA_W-1:DATA_W-1]));
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt            <= '0;
      acc            <= '0;
      opnd_b         <= '0;
      op_div         <= 1'b0;
      neg            <= 1'b0;
      special        <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
    end else begin
      data_resultRDY <= finish;
      if (finish) begin
        data_result    <= fin_res;
        data_exception <= fin_exc;
      end
      if (load) begin
        cnt     <= '0;
        op_div  <= !ctrl_MULT;
        neg     <= data_operandA[DATA_W-1] ^ data_operandB[DATA_W-1];
        acc     <= {{DATA_W{1'b0}}, mag(data_operandA)};
        opnd_b  <= mag(data_operandB);
        special <= !ctrl_MULT && ((data_operandB == '0) ||
                   ((data_operandA == INT_MIN) && (data_operandB == {DATA_W{1'b1}})));
      end else if (step) begin
        cnt <= cnt + CNT_W'(1);
        acc <= op_div ? {rem_nxt, quo_nxt} : mult_nxt;
      end
    end
  end

endmodule

// File: tb/tb_multdiv.sv
// Self-checking bench for multdiv: directed corner cases plus random operands against an arithmetic model.
module tb_multdiv;

  logic [31:0] operand_a, operand_b;
  logic        ctrl_mult, ctrl_div;
  logic        clock, reset;
  logic [31:0] result;
  logic        exception, result_rdy;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] got_res;
  logic        got_exc;

  multdiv #(.DATA_W(32)) dut (
    .data_operandA  (operand_a),
    .data_operandB  (operand_b),
    .ctrl_MULT      (ctrl_mult),
    .ctrl_DIV       (ctrl_div),
    .clock          (clock),
    .data_result    (result),
    .data_exception (exception),
    .data_resultRDY (result_rdy),
    .reset          (reset)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d (0x%08h), expected %0d (0x%08h)", tag, $signed(obs), obs, $signed(exp), exp);
    end
  endtask

  // Reference: exact 64-bit product, C-style truncating division, explicit error cases.
  function automatic void model(input bit mul, input logic signed [31:0] a, input logic signed [31:0] b,
                                output logic [31:0] r, output logic e);
    longint p;
    longint lim_hi, lim_lo;
    lim_hi = 64'sd2147483647;
    lim_lo = -64'sd2147483648;
    if (mul) begin
      p = longint'(a) * longint'(b);
      r = p[31:0];
      e = (p > lim_hi) || (p < lim_lo);
    end else if (b == 0 || (a == 32'sh80000000 && b == -32'sd1)) begin
      r = 32'd0;
      e = 1'b1;
    end else begin
      r = a / b;
      e = 1'b0;
    end
  endfunction

  function automatic logic [31:0] pick();
    logic [31:0] corner [5];
    corner = '{32'h80000000, 32'h7fffffff, 32'hffffffff, 32'h0, 32'h1};
    case ($urandom_range(0, 3))
      0:       return $urandom;
      1:       return 32'($urandom_range(0, 200)) - 32'd100;
      2:       return 32'($urandom_range(0, 131071)) - 32'd65536;
      default: return corner[$urandom_range(0, 4)];
    endcase
  endfunction

  // Start edge is the posedge inside this task; returns 1 time unit after it with operands scrambled.
  task automatic launch(input bit mul, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    operand_a = a;
    operand_b = b;
    ctrl_mult = mul;
    ctrl_div  = !mul;
    @(posedge clock);
    #1;
    ctrl_mult = 1'b0;
    ctrl_div  = 1'b0;
    operand_a = $urandom;
    operand_b = $urandom;
  endtask

  task automatic await_rdy(input int budget, output int lat, output int pulses);
    lat    = -1;
    pulses = 0;
    for (int i = 1; i <= budget; i++) begin
      @(posedge clock);
      #1;
      if (result_rdy) begin
        pulses++;
        if (lat < 0) begin
          lat     = i;
          got_res = result;
          got_exc = exception;
        end
      end
    end
  endtask

  task automatic do_op(input string tag, input bit mul, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] er;
    logic        ee;
    int          lat, pulses;
    launch(mul, a, b);
    await_rdy(40, lat, pulses);
    model(mul, a, b, er, ee);
    check({tag, " latency"}, lat, 33);
    check({tag, " pulses"}, pulses, 1);
    check({tag, " result"}, got_res, er);
    check({tag, " exception"}, {31'd0, got_exc}, {31'd0, ee});
  endtask

  initial begin
    int          lat, pulses;
    logic [31:0] ra, rb;
    bit          mul;

    reset     = 1'b1;
    ctrl_mult = 1'b0;
    ctrl_div  = 1'b0;
    operand_a = 32'd0;
    operand_b = 32'd0;
    repeat (2) @(negedge clock);
    check("reset result", result, 32'd0);
    check("reset exception", {31'd0, exception}, 32'd0);
    check("reset rdy", {31'd0, result_rdy}, 32'd0);
    reset = 1'b0;

    await_rdy(5, lat, pulses);
    check("idle no pulse", pulses, 0);

    do_op("mul 7*-3", 1'b1, 32'd7, -32'd3);
    repeat (3) @(posedge clock);
    #1;
    check("hold result", result, -32'd21);
    do_op("mul 65536*65536", 1'b1, 32'd65536, 32'd65536);
    do_op("mul -65536*32768", 1'b1, -32'd65536, 32'd32768);
    do_op("div -100/7", 1'b0, -32'd100, 32'd7);
    do_op("div 100/-7", 1'b0, 32'd100, -32'd7);
    do_op("div 5/0", 1'b0, 32'd5, 32'd0);
    do_op("div min/-1", 1'b0, 32'h80000000, 32'hffffffff);
    do_op("mul min*-1", 1'b1, 32'h80000000, 32'hffffffff);
    do_op("div min/1", 1'b0, 32'h80000000, 32'd1);

    // Restart during a multiply: only the divide completes, timed from its own start.
    launch(1'b1, 32'd3, 32'd4);
    @(posedge clock);
    launch(1'b0, 32'd20, 32'd5);
    await_rdy(40, lat, pulses);
    check("abort pulses", pulses, 1);
    check("abort latency", lat, 33);
    check("abort result", got_res, 32'd4);
    check("abort exception", {31'd0, got_exc}, 32'd0);

    // Reset in the middle of a multiply.
    launch(1'b1, 32'h12345, 32'h777);
    repeat (9) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("midreset result", result, 32'd0);
    check("midreset exception", {31'd0, exception}, 32'd0);
    check("midreset rdy", {31'd0, result_rdy}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    await_rdy(40, lat, pulses);
    check("midreset no pulse", pulses, 0);
    do_op("mul 2*2 after reset", 1'b1, 32'd2, 32'd2);

    // Start arriving in the DONE cycle: old result still reported, new operation proceeds.
    launch(1'b1, 32'd6, 32'd7);
    repeat (32) @(posedge clock);
    launch(1'b0, 32'd100, -32'd7);
    check("done+start rdy", {31'd0, result_rdy}, 32'd1);
    check("done+start result", result, 32'd42);
    await_rdy(40, lat, pulses);
    check("done+start latency", lat, 33);
    check("done+start next result", got_res, -32'd14);

    for (int i = 0; i < 32; i++) begin
      mul = (i % 2) == 0;
      ra  = pick();
      rb  = pick();
      do_op(mul ? "rand mul" : "rand div", mul, ra, rb);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
